tlc_phase_sequencer: RTL and testbench
======================================

Name: tlc_phase_sequencer

Overview:
Timed phase sequencer for the highway/farm-road intersection.
- Replaces sensor-only stepping with per-phase dwell timers and sticky request latches.
- Adds a farm green phase with car-presence extension, and all-red clearance intervals.
- Drives the lamp outputs directly and sits between the raw road sensors and the signal-head drivers.

Parameters:
TW, 8, width of the dwell counter
MIN_GREEN, 8, minimum highway-green dwell in cycles (>=1)
LEFT_T, 4, highway left-arrow dwell in cycles (>=1)
YELLOW_T, 3, yellow dwell for either road in cycles (>=1)
ALLRED_T, 2, all-red clearance dwell in cycles (>=1)
FARM_MIN, 5, minimum farm-green dwell in cycles (>=1)
FARM_MAX, 12, maximum farm-green dwell in cycles (>=FARM_MIN, <=2^TW-1)

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
FARM_CAR  in  1  farm-road car detector, level, synchronous to CLOCK
HL_CAR  in  1  highway left-turn lane detector, level
HGREEN/HYELLOW/HRED/HLEFT  out  1 each  highway lamps
FGREEN/FYELLOW/FRED  out  1 each  farm lamps
PHASE  out  3  current state encoding

Behaviour:
Interface: one clock, CLOCK. RESET is asynchronous and active-high.

State encoding and lamps (Moore decode of the state register, so lamps change on the transition edge):
- HG=0: HGREEN, FRED
- HL=1: HLEFT, FRED
- HY=2: HYELLOW, FRED
- AR1=3: HRED, FRED
- FG=4: HRED, FGREEN
- FY=5: HRED, FYELLOW
- AR2=6: HRED, FRED
- 7 is illegal: decodes to HRED, FRED and goes to AR2 on the next edge.
- All lamp outputs not listed for a state are 0.

Reset:
- State=HG, cnt=0, farm_pend=0, hl_pend=0.
- Outputs: HGREEN=1, FRED=1, all other lamps 0, PHASE=0.
- Takes effect immediately and mid-phase, with no completion of the current phase.

Dwell counter cnt (TW bits):
- Clears to 0 on every edge where the state changes.
- Otherwise increments, saturating at 2^TW-1.
- A dwell of N cycles means the transition is taken on the edge where cnt==N-1.

Request latches:
- farm_pend: set on any edge with FARM_CAR=1 while state!=FG; cleared on the edge entering FG (clear wins over a simultaneous set).
- hl_pend: set on HL_CAR=1 while state!=HL; cleared on the edge entering HL (clear wins).
- A 1-cycle sensor pulse must be remembered.

Transitions:
- HG: when cnt>=MIN_GREEN-1 and (hl_pend or farm_pend): go to HL if hl_pend, else HY. Otherwise hold indefinitely.
- HL: at cnt==LEFT_T-1, go to HY if farm_pend, else HG.
- HY: at cnt==YELLOW_T-1, go to AR1.
- AR1: at cnt==ALLRED_T-1, go to FG.
- FG: go to FY when (cnt>=FARM_MIN-1 and FARM_CAR=0) or cnt==FARM_MAX-1.
- FY: at cnt==YELLOW_T-1, go to AR2.
- AR2: at cnt==ALLRED_T-1, go to HG.

Boundary conditions and invariants:
- Requests arriving during HY/AR1 (farm) are absorbed by the upcoming FG.
- Left requests arriving during farm phases are served on the next HG exit.
- Green or yellow is never asserted on both roads simultaneously.
- HRED and FRED are both 1 only in AR1, AR2 and the illegal state.

Test Plan:
1. Release reset, hold FARM_CAR=HL_CAR=0 for 50 cycles -> PHASE=0 throughout, HGREEN=1, FRED=1, all other lamps 0.
2. 1-cycle FARM_CAR pulse at cycle 2 (HG entered at cycle 0) -> phase sequence:
   - HG cycles 0-7, HY 8-10, AR1 11-12, FG 13-17, FY 18-20, AR2 21-22, HG from 23.
   - HG then holds, since farm_pend was cleared at FG entry.
3. FARM_CAR held at 1 -> FG lasts exactly 12 cycles (FARM_MAX); farm_pend re-sets during FY/AR2; the next HG lasts 8 cycles before repeating HY.
4. 1-cycle HL_CAR pulse at cycle 3, no farm request -> HG 0-7, HL 8-11 (HLEFT=1, FRED=1), HG from 12, then holds.
5. HL_CAR and FARM_CAR both pulsed at cycle 1 -> HG 0-7, HL 8-11, HY 12-14, AR1 15-16, FG 17-21, FY 22-24, AR2 25-26, HG 27.
6. RESET asserted asynchronously mid-FG (between edges) -> immediately PHASE=0, HGREEN=1, FRED=1, FGREEN=0; pending requests are lost, and after release HG holds until a new request.

Source files
------------

// File: rtl/tlc_phase_sequencer.sv
// Highway/farm-road phase sequencer: per-phase dwell timers, sticky sensor requests, all-red clearance.
// Lamps are a Moore decode of the state register; no backpressure (free-running controller).
module tlc_phase_sequencer #(
  parameter int TW        = 8,
  parameter int MIN_GREEN = 8,
  parameter int LEFT_T    = 4,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int FARM_MIN  = 5,
  parameter int FARM_MAX  = 12
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       FARM_CAR,
  input  logic       HL_CAR,
  output logic       HGREEN,
  output logic       HYELLOW,
  output logic       HRED,
  output logic       HLEFT,
  output logic       FGREEN,
  output logic       FYELLOW,
  output logic       FRED,
  output logic [2:0] PHASE
);

  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HL  = 3'd1;
  localparam logic [2:0] S_HY  = 3'd2;
  localparam logic [2:0] S_AR1 = 3'd3;
  localparam logic [2:0] S_FG  = 3'd4;
  localparam logic [2:0] S_FY  = 3'd5;
  localparam logic [2:0] S_AR2 = 3'd6;

  localparam logic [TW-1:0] MG_LAST   = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] LEFT_LAST = TW'(LEFT_T - 1);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] FMIN_LAST = TW'(FARM_MIN - 1);
  localparam logic [TW-1:0] FMAX_LAST = TW'(FARM_MAX - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          farm_pend_q, farm_pend_d;
  logic          hl_pend_q, hl_pend_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HG:  if (cnt_q >= MG_LAST && (hl_pend_q || farm_pend_q))
               state_d = hl_pend_q ? S_HL : S_HY;
      S_HL:  if (cnt_q == LEFT_LAST) state_d = farm_pend_q ? S_HY : S_HG;
      S_HY:  if (cnt_q == YEL_LAST) state_d = S_AR1;
      S_AR1: if (cnt_q == AR_LAST) state_d = S_FG;
      // Extend farm green while a car is present, capped at the maximum dwell.
      S_FG:  if ((cnt_q >= FMIN_LAST && !FARM_CAR) || cnt_q == FMAX_LAST)
               state_d = S_FY;
      S_FY:  if (cnt_q == YEL_LAST) state_d = S_AR2;
      S_AR2: if (cnt_q == AR_LAST) state_d = S_HG;
      default: state_d = S_AR2;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);
  end

  // Entering the serving phase clears the request even if the sensor is still high.
  always_comb begin
    farm_pend_d = farm_pend_q;
    if (state_d == S_FG && state_q != S_FG)
      farm_pend_d = 1'b0;
    else if (FARM_CAR && state_q != S_FG)
      farm_pend_d = 1'b1;

    hl_pend_d = hl_pend_q;
    if (state_d == S_HL && state_q != S_HL)
      hl_pend_d = 1'b0;
    else if (HL_CAR && state_q != S_HL)
      hl_pend_d = 1'b1;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_HG;
      cnt_q       <= '0;
      farm_pend_q <= 1'b0;
      hl_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      farm_pend_q <= farm_pend_d;
      hl_pend_q   <= hl_pend_d;
    end
  end

  always_comb begin
    HGREEN  = 1'b0;
    HYELLOW = 1'b0;
    HRED    = 1'b0;
    HLEFT   = 1'b0;
    FGREEN  = 1'b0;
    FYELLOW = 1'b0;
    FRED    = 1'b0;
    case (state_q)
      S_HG:  begin HGREEN  = 1'b1; FRED = 1'b1; end
      S_HL:  begin HLEFT   = 1'b1; FRED = 1'b1; end
      S_HY:  begin HYELLOW = 1'b1; FRED = 1'b1; end
      S_FG:  begin HRED = 1'b1; FGREEN  = 1'b1; end
      S_FY:  begin HRED = 1'b1; FYELLOW = 1'b1; end
      default: begin HRED = 1'b1; FRED = 1'b1; end
    endcase
  end

  assign PHASE = state_q;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Directed bench for tlc_phase_sequencer: phase timelines per cycle with hand-derived boundaries.
module tb_tlc_phase_sequencer;

  localparam logic [2:0] HG = 3'd0, HL = 3'd1, HY = 3'd2, AR1 = 3'd3,
                         FG = 3'd4, FY = 3'd5, AR2 = 3'd6;

  logic       CLOCK, RESET, FARM_CAR, HL_CAR;
  logic       HGREEN, HYELLOW, HRED, HLEFT, FGREEN, FYELLOW, FRED;
  logic [2:0] PHASE;

  int n_checks = 0;
  int n_fail   = 0;

  tlc_phase_sequencer dut (
    .CLOCK(CLOCK), .RESET(RESET), .FARM_CAR(FARM_CAR), .HL_CAR(HL_CAR),
    .HGREEN(HGREEN), .HYELLOW(HYELLOW), .HRED(HRED), .HLEFT(HLEFT),
    .FGREEN(FGREEN), .FYELLOW(FYELLOW), .FRED(FRED), .PHASE(PHASE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // {HGREEN,HYELLOW,HRED,HLEFT,FGREEN,FYELLOW,FRED} expected for a phase.
  function automatic logic [6:0] lamps_for(input logic [2:0] p);
    case (p)
      HG:      return 7'b1000001;
      HL:      return 7'b0001001;
      HY:      return 7'b0100001;
      FG:      return 7'b0010100;
      FY:      return 7'b0010010;
      default: return 7'b0010001;
    endcase
  endfunction

  function automatic logic [6:0] lamps_now();
    return {HGREEN, HYELLOW, HRED, HLEFT, FGREEN, FYELLOW, FRED};
  endfunction

  // Reset sequencing only; leaves the bench at a falling edge = cycle 0 of HG.
  task automatic do_reset();
    FARM_CAR = 1'b0;
    HL_CAR   = 1'b0;
    RESET    = 1'b1;
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    RESET = 1'b0; FARM_CAR = 1'b0; HL_CAR = 1'b0;
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if (PHASE !== HG || lamps_now() !== 7'b1000001) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d lamps=%b, want phase=0 lamps=1000001", PHASE, lamps_now());
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    for (int k = 0; k < 50; k++) begin
      exp = HG;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic test_farm_pulse();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k < 45; k++) begin
      FARM_CAR = (k == 2);
      exp = (k < 8) ? HG : (k < 11) ? HY : (k < 13) ? AR1 : (k < 18) ? FG :
            (k < 21) ? FY : (k < 23) ? AR2 : HG;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL farm_pulse cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      n_checks++;
      if ((HGREEN | HYELLOW | HLEFT) & (FGREEN | FYELLOW)) begin
        n_fail++;
        $display("FAIL conflict cycle %0d: lamps=%b, want no cross-road go", k, lamps_now());
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic test_farm_max();
    logic [2:0] exp;
    do_reset();
    FARM_CAR = 1'b1;
    for (int k = 0; k < 40; k++) begin
      exp = (k < 8) ? HG : (k < 11) ? HY : (k < 13) ? AR1 : (k < 25) ? FG :
            (k < 28) ? FY : (k < 30) ? AR2 : (k < 38) ? HG : HY;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL farm_max cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      @(negedge CLOCK);
    end
    FARM_CAR = 1'b0;
  endtask

  task automatic test_extension();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      FARM_CAR = (k == 2) || (k >= 14 && k <= 19);
      exp = (k < 8) ? HG : (k < 11) ? HY : (k < 13) ? AR1 : (k < 21) ? FG :
            (k < 24) ? FY : (k < 26) ? AR2 : HG;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL extension cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic test_left_pulse();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      HL_CAR = (k == 3);
      exp = (k < 8) ? HG : (k < 12) ? HL : HG;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL left_pulse cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic test_left_and_farm();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      HL_CAR   = (k == 1);
      FARM_CAR = (k == 1);
      exp = (k < 8) ? HG : (k < 12) ? HL : (k < 15) ? HY : (k < 17) ? AR1 :
            (k < 22) ? FG : (k < 25) ? FY : (k < 27) ? AR2 : HG;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL left_and_farm cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      @(negedge CLOCK);
    end
  endtask

  // Farm request during HY is absorbed; left request during FG is served after the next HG.
  task automatic test_back_to_back();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k < 50; k++) begin
      FARM_CAR = (k == 2) || (k == 9);
      HL_CAR   = (k == 14);
      exp = (k < 8) ? HG : (k < 11) ? HY : (k < 13) ? AR1 : (k < 18) ? FG :
            (k < 21) ? FY : (k < 23) ? AR2 : (k < 31) ? HG : (k < 35) ? HL : HG;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      FARM_CAR = (k == 2);
      HL_CAR   = (k == 14);
      @(negedge CLOCK);
    end
    HL_CAR = 1'b0;
    n_checks++;
    if (PHASE !== FG) begin
      n_fail++;
      $display("FAIL async_pre cycle 15: phase=%0d, want phase=%0d", PHASE, FG);
    end
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if (PHASE !== HG || HGREEN !== 1'b1 || FRED !== 1'b1 || FGREEN !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: phase=%0d lamps=%b, want phase=0 HGREEN=1 FRED=1 FGREEN=0",
               PHASE, lamps_now());
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    for (int k = 0; k < 30; k++) begin
      exp = HG;
      n_checks++;
      if (PHASE !== exp || lamps_now() !== lamps_for(exp)) begin
        n_fail++;
        $display("FAIL after_reset cycle %0d: phase=%0d lamps=%b, want phase=%0d lamps=%b",
                 k, PHASE, lamps_now(), exp, lamps_for(exp));
      end
      @(negedge CLOCK);
    end
  endtask

  initial begin
    test_reset();
    test_farm_pulse();
    test_farm_max();
    test_extension();
    test_left_pulse();
    test_left_and_farm();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
